// File: rtl/lrsc_reservation_monitor.sv
// LR/SC reservation monitor: one reservation per hart, SC grant/fail, 1-entry response stage.
// Optional reservation lifetime counters are built when LRSC_TIMEOUT_EN is defined.
module lrsc_reservation_monitor #(
   parameter int unsigned NHARTS         = 2,
   parameter int unsigned PA_BITS        = 56,
   parameter int unsigned XLEN           = 64,
   parameter int unsigned TIMEOUT_CYCLES = 64,
   localparam int unsigned HART_BITS     = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 ReqValid,
   output logic                 ReqReady,
   input  logic [HART_BITS-1:0] ReqHart,
   input  logic [1:0]           ReqOp,
   input  logic [PA_BITS-1:0]   ReqPAdr,
   input  logic                 SnoopWrValid,
   input  logic [PA_BITS-1:0]   SnoopPAdr,
   output logic                 RspValid,
   input  logic                 RspReady,
   output logic [HART_BITS-1:0] RspHart,
   output logic [1:0]           RspOp,
   output logic                 RspSCFail,
   output logic [NHARTS-1:0]    ResValidOut
);

   localparam int unsigned GRAN_LSB = $clog2(XLEN / 8);
   localparam int unsigned GW       = PA_BITS - GRAN_LSB;

   localparam logic [1:0] OpRead  = 2'b00;
   localparam logic [1:0] OpWrite = 2'b01;
   localparam logic [1:0] OpLr    = 2'b10;
   localparam logic [1:0] OpSc    = 2'b11;

   logic [NHARTS-1:0]    resVQ, resVD;
   logic [GW-1:0]        resAQ [NHARTS];
   logic [GW-1:0]        resAD [NHARTS];
   logic [NHARTS-1:0]    isHart;
   logic [GW-1:0]        reqGran, snoopGran;
   logic                 accept, hartOk, scOk, rspFailD;

   logic                 rspValidQ;
   logic [HART_BITS-1:0] rspHartQ;
   logic [1:0]           rspOpQ;
   logic                 rspSCFailQ;

   logic                 unusedLowBits;

`ifdef LRSC_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cntQ [NHARTS];
   logic [CNT_W-1:0] cntD [NHARTS];
`else
   logic unusedTimeout;
   assign unusedTimeout = ^TIMEOUT_CYCLES;
`endif

   assign unusedLowBits = ^{ReqPAdr[GRAN_LSB-1:0], SnoopPAdr[GRAN_LSB-1:0]};

   assign reqGran   = ReqPAdr[PA_BITS-1:GRAN_LSB];
   assign snoopGran = SnoopPAdr[PA_BITS-1:GRAN_LSB];
   assign ReqReady  = ~rspValidQ | RspReady;
   assign accept    = ReqValid & ReqReady;

   always_comb begin
      resVD  = resVQ;
      resAD  = resAQ;
      isHart = '0;
      scOk   = 1'b0;
      for (int j = 0; j < NHARTS; j++) begin
         isHart[j] = (ReqHart == HART_BITS'(j));
      end
      hartOk = |isHart;

      // Snoop clears first, so a same-cycle SC to that granule sees no reservation.
      for (int j = 0; j < NHARTS; j++) begin
         if (SnoopWrValid && (resAQ[j] == snoopGran)) resVD[j] = 1'b0;
      end
      for (int j = 0; j < NHARTS; j++) begin
         if (isHart[j]) scOk = resVD[j] && (resAQ[j] == reqGran);
      end

      if (accept) begin
         case (ReqOp)
            OpWrite: begin
               for (int j = 0; j < NHARTS; j++) begin
                  if (hartOk && !isHart[j] && (resAQ[j] == reqGran)) resVD[j] = 1'b0;
               end
            end
            OpLr: begin
               for (int j = 0; j < NHARTS; j++) begin
                  if (isHart[j]) begin
                     resVD[j] = 1'b1;
                     resAD[j] = reqGran;
                  end
               end
            end
            OpSc: begin
               for (int j = 0; j < NHARTS; j++) begin
                  if (isHart[j]) resVD[j] = 1'b0;
                  else if (scOk && (resAQ[j] == reqGran)) resVD[j] = 1'b0;
               end
            end
            default: ;
         endcase
      end
      rspFailD = (ReqOp == OpSc) && !scOk;

`ifdef LRSC_TIMEOUT_EN
      // Expiry is applied last, so an SC in the final live cycle still succeeds.
      for (int j = 0; j < NHARTS; j++) begin
         cntD[j] = cntQ[j];
         if (accept && (ReqOp == OpLr) && isHart[j]) begin
            cntD[j] = CNT_W'(TIMEOUT_CYCLES);
         end else if (resVQ[j]) begin
            if (cntQ[j] <= CNT_W'(1)) begin
               cntD[j]  = '0;
               resVD[j] = 1'b0;
            end else begin
               cntD[j] = cntQ[j] - CNT_W'(1);
            end
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         resVQ      <= '0;
         for (int j = 0; j < NHARTS; j++) resAQ[j] <= '0;
         rspValidQ  <= 1'b0;
         rspHartQ   <= '0;
         rspOpQ     <= '0;
         rspSCFailQ <= 1'b0;
      end else begin
         resVQ <= resVD;
         resAQ <= resAD;
         if (accept) begin
            rspValidQ  <= 1'b1;
            rspHartQ   <= ReqHart;
            rspOpQ     <= ReqOp;
            rspSCFailQ <= rspFailD;
         end else if (RspReady) begin
            rspValidQ  <= 1'b0;
         end
      end
   end

`ifdef LRSC_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int j = 0; j < NHARTS; j++) cntQ[j] <= '0;
      end else begin
         cntQ <= cntD;
      end
   end
`endif

   assign RspValid    = rspValidQ;
   assign RspHart     = rspHartQ;
   assign RspOp       = rspOpQ;
   assign RspSCFail   = rspSCFailQ;
   assign ResValidOut = resVQ;

endmodule

// File: tb/tb_lrsc_reservation_monitor.sv
// Directed bench for lrsc_reservation_monitor (3 harts so an out-of-range hart id is reachable).
module tb_lrsc_reservation_monitor;

   localparam int unsigned NHARTS = 3;
   localparam int unsigned PA_BITS = 56;
   localparam int unsigned HART_BITS = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 ReqValid, ReqReady;
   logic [HART_BITS-1:0] ReqHart;
   logic [1:0]           ReqOp;
   logic [PA_BITS-1:0]   ReqPAdr;
   logic                 SnoopWrValid;
   logic [PA_BITS-1:0]   SnoopPAdr;
   logic                 RspValid, RspReady;
   logic [HART_BITS-1:0] RspHart;
   logic [1:0]           RspOp;
   logic                 RspSCFail;
   logic [NHARTS-1:0]    ResValidOut;

   int nAsserts = 0;
   int nFail = 0;

   lrsc_reservation_monitor #(
      .NHARTS(NHARTS), .PA_BITS(PA_BITS), .XLEN(64), .TIMEOUT_CYCLES(4)
   ) dut (
      .clk(clk), .reset(reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
      .ReqHart(ReqHart), .ReqOp(ReqOp), .ReqPAdr(ReqPAdr),
      .SnoopWrValid(SnoopWrValid), .SnoopPAdr(SnoopPAdr),
      .RspValid(RspValid), .RspReady(RspReady), .RspHart(RspHart), .RspOp(RspOp),
      .RspSCFail(RspSCFail), .ResValidOut(ResValidOut)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic [1:0] hart, input logic [1:0] op, input logic [55:0] adr,
                       input logic snp, input logic [55:0] sadr);
      ReqValid = 1'b1; ReqHart = hart; ReqOp = op; ReqPAdr = adr;
      SnoopWrValid = snp; SnoopPAdr = sadr;
      @(posedge clk); #1;
      ReqValid = 1'b0; SnoopWrValid = 1'b0;
   endtask

   task automatic idle();
      ReqValid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic rsp(input string tag, input logic [1:0] hart, input logic [1:0] op,
                      input logic fail, input logic [2:0] res);
      check({tag, ".valid"}, RspValid, 1);
      check({tag, ".hart"}, RspHart, hart);
      check({tag, ".op"}, RspOp, op);
      check({tag, ".scfail"}, RspSCFail, fail);
      check({tag, ".resv"}, ResValidOut, res);
   endtask

   initial begin
      reset = 1'b0; ReqValid = 1'b0; ReqHart = '0; ReqOp = '0; ReqPAdr = '0;
      SnoopWrValid = 1'b0; SnoopPAdr = '0; RspReady = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      check("reset.valid", RspValid, 0);
      check("reset.scfail", RspSCFail, 0);
      check("reset.resv", ResValidOut, 0);
      check("reset.ready", ReqReady, 1);
      reset = 1'b1;

      // Same granule, different byte offset
      step(0, 2'b10, 56'h1000, 0, 0); rsp("lr1", 0, 2'b10, 0, 3'b001);
      step(0, 2'b11, 56'h1004, 0, 0); rsp("sc1", 0, 2'b11, 0, 3'b000);

      step(0, 2'b10, 56'h1000, 0, 0); rsp("lr2", 0, 2'b10, 0, 3'b001);
      step(1, 2'b01, 56'h1008, 0, 0); rsp("wr2", 1, 2'b01, 0, 3'b001);
      step(0, 2'b11, 56'h1000, 0, 0); rsp("sc2", 0, 2'b11, 0, 3'b000);

      step(0, 2'b10, 56'h1000, 0, 0); rsp("lr3", 0, 2'b10, 0, 3'b001);
      step(1, 2'b01, 56'h1000, 0, 0); rsp("wr3", 1, 2'b01, 0, 3'b000);
      step(0, 2'b11, 56'h1000, 0, 0); rsp("sc3", 0, 2'b11, 1, 3'b000);

      // Own write keeps own reservation
      step(0, 2'b10, 56'h1000, 0, 0); rsp("lr4", 0, 2'b10, 0, 3'b001);
      step(0, 2'b01, 56'h1000, 0, 0); rsp("wr4", 0, 2'b01, 0, 3'b001);
      step(0, 2'b11, 56'h1000, 0, 0); rsp("sc4", 0, 2'b11, 0, 3'b000);

      step(0, 2'b10, 56'h2000, 0, 0); rsp("lr5a", 0, 2'b10, 0, 3'b001);
      step(1, 2'b10, 56'h2000, 0, 0); rsp("lr5b", 1, 2'b10, 0, 3'b011);
      step(1, 2'b11, 56'h2000, 0, 0); rsp("sc5b", 1, 2'b11, 0, 3'b000);
      step(0, 2'b11, 56'h2000, 0, 0); rsp("sc5a", 0, 2'b11, 1, 3'b000);

      step(0, 2'b10, 56'h3000, 0, 0); rsp("lr6", 0, 2'b10, 0, 3'b001);
      step(0, 2'b11, 56'h3000, 1, 56'h3000); rsp("sc6snp", 0, 2'b11, 1, 3'b000);
      step(0, 2'b10, 56'h3000, 0, 0); rsp("lr7", 0, 2'b10, 0, 3'b001);
      step(0, 2'b11, 56'h3000, 1, 56'h3008); rsp("sc7snp", 0, 2'b11, 0, 3'b000);

      // Hart id 3 is out of range
      step(0, 2'b10, 56'h4000, 0, 0); rsp("lr8", 0, 2'b10, 0, 3'b001);
      step(3, 2'b01, 56'h4000, 0, 0); rsp("wr8bad", 3, 2'b01, 0, 3'b001);
      step(3, 2'b10, 56'h4000, 0, 0); rsp("lr8bad", 3, 2'b10, 0, 3'b001);
      step(3, 2'b11, 56'h4000, 0, 0); rsp("sc8bad", 3, 2'b11, 1, 3'b001);
      step(0, 2'b11, 56'h4000, 0, 0); rsp("sc8", 0, 2'b11, 0, 3'b000);

      step(0, 2'b10, 56'h5000, 0, 0); rsp("lr9a", 0, 2'b10, 0, 3'b001);
      step(0, 2'b10, 56'h6000, 0, 0); rsp("lr9b", 0, 2'b10, 0, 3'b001);
      step(0, 2'b11, 56'h5000, 0, 0); rsp("sc9", 0, 2'b11, 1, 3'b000);
      step(2, 2'b00, 56'h6000, 0, 0); rsp("rd9", 2, 2'b00, 0, 3'b000);

      // Stall with snoop, then reset during the stall
      idle();
      check("idle.valid", RspValid, 0);
      RspReady = 1'b0;
      step(0, 2'b10, 56'h7000, 0, 0); rsp("lrStall", 0, 2'b10, 0, 3'b001);
      ReqValid = 1'b1; ReqHart = 0; ReqOp = 2'b11; ReqPAdr = 56'h7000;
      for (int i = 0; i < 5; i++) begin
         SnoopWrValid = (i == 2); SnoopPAdr = 56'h7000;
         check("stall.ready", ReqReady, 0);
         @(posedge clk); #1;
         rsp("stall", 0, 2'b10, 0, (i >= 2) ? 3'b000 : 3'b001);
      end
      SnoopWrValid = 1'b0;
      reset = 1'b0; RspReady = 1'b1; ReqOp = 2'b10;
      @(posedge clk); #1;
      check("rstStall.valid", RspValid, 0);
      check("rstStall.resv", ResValidOut, 0);
      reset = 1'b1; ReqValid = 1'b0;
      idle();
      check("postRst.valid", RspValid, 0);
      step(0, 2'b11, 56'h7000, 0, 0); rsp("scAfterRst", 0, 2'b11, 1, 3'b000);

`ifdef LRSC_TIMEOUT_EN
      step(0, 2'b10, 56'h8000, 0, 0); rsp("toLr1", 0, 2'b10, 0, 3'b001);
      idle(); idle();
      step(0, 2'b11, 56'h8000, 0, 0); rsp("toSc1", 0, 2'b11, 0, 3'b000);
      step(0, 2'b10, 56'h8000, 0, 0); rsp("toLr2", 0, 2'b10, 0, 3'b001);
      idle(); idle(); idle();
      check("toLive", ResValidOut, 3'b001);
      idle();
      check("toExpired", ResValidOut, 3'b000);
      step(0, 2'b11, 56'h8000, 0, 0); rsp("toSc2", 0, 2'b11, 1, 3'b000);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
      $finish;
   end

endmodule
